// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default widths, the hardwired-zero
// register index and the register-file clear/run state encoding.
package mips_pkg;

    localparam int MIPS_DATA_W   = 32;
    localparam int MIPS_ADDR_W   = 5;
    localparam int MIPS_REG_ZERO = 0;

    localparam logic [0:0] RF_CLEAR = 1'b0;
    localparam logic [0:0] RF_RUN   = 1'b1;

endpackage

// File: rtl/mips_regfile_clear_seq.sv
// Post-reset clear sequencer for the register file: walks every address
// once writing zero, then raises ready and stays in RUN until the next reset.
module mips_regfile_clear_seq
    import mips_pkg::*;
#(
    parameter int ADDR_W = MIPS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;

    // State bit, sweep counter and ready flag; reset always restarts a full sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == RF_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
                state <= RF_RUN;
                ready <= 1'b1;
            end
        end
    end

    // Clear write strobe is active for every cycle spent in CLEAR
    always_comb begin
        clr_we   = (state == RF_CLEAR);
        clr_addr = cnt;
    end

endmodule

// File: rtl/mips_regfile_gen.sv
// Parametrised MIPS register file: two registered read ports, one write
// port, optional hardwired $zero and optional write-to-read bypass.
// Storage has no reset so it can map to RAM; a clear sweep zeroes it instead.
module mips_regfile_gen
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              signal_reg_write,
    output logic              ready
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(MIPS_REG_ZERO);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    mips_regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Write port mux: the clear sweep owns storage until ready, user writes after
    always_comb begin
        user_we   = signal_reg_write && !((ZERO_REG != 0) && (write_reg == ZERO_ADDR));
        mem_we    = 1'b0;
        mem_addr  = write_reg;
        mem_wdata = write_data;
        if (!rst) begin
            if (ready) begin
                mem_we = user_we;
            end else begin
                mem_we    = clr_we;
                mem_addr  = clr_addr;
                mem_wdata = '0;
            end
        end
    end

    // Storage array, single write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Next read values: $zero check wins, then bypass, then stored contents
    always_comb begin
        rd1_next = mem[read_reg_1];
        rd2_next = mem[read_reg_2];
        if ((ZERO_REG != 0) && (read_reg_1 == ZERO_ADDR)) begin
            rd1_next = '0;
        end else if ((BYPASS != 0) && user_we && (write_reg == read_reg_1)) begin
            rd1_next = write_data;
        end
        if ((ZERO_REG != 0) && (read_reg_2 == ZERO_ADDR)) begin
            rd2_next = '0;
        end else if ((BYPASS != 0) && user_we && (write_reg == read_reg_2)) begin
            rd2_next = write_data;
        end
    end

    // Registered read ports, forced to zero in reset and during the clear sweep
    always_ff @(posedge clk) begin
        if (rst || !ready) begin
            read_data_1 <= '0;
            read_data_2 <= '0;
        end else begin
            read_data_1 <= rd1_next;
            read_data_2 <= rd2_next;
        end
    end

endmodule

// File: tb/tb_mips_regfile_gen.sv
// Directed bench for mips_regfile_gen: default configuration, a no-bypass /
// ordinary-$zero configuration and a narrow 16x8 configuration side by side.
module tb_mips_regfile_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Shared inputs for the two 32x32 instances
    logic [4:0]  rr1 = '0, rr2 = '0, wr = '0;
    logic [31:0] wd = '0;
    logic        we = 1'b0;
    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_ready, b_ready;

    // Inputs for the 16x8 instance
    logic [2:0]  s_rr1 = '0, s_rr2 = '0, s_wr = '0;
    logic [15:0] s_wd = '0;
    logic        s_we = 1'b0;
    logic [15:0] s_rd1, s_rd2;
    logic        s_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_regfile_gen #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .read_reg_1(rr1), .read_reg_2(rr2),
        .read_data_1(a_rd1), .read_data_2(a_rd2), .write_reg(wr),
        .write_data(wd), .signal_reg_write(we), .ready(a_ready));

    mips_regfile_gen #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .read_reg_1(rr1), .read_reg_2(rr2),
        .read_data_1(b_rd1), .read_data_2(b_rd2), .write_reg(wr),
        .write_data(wd), .signal_reg_write(we), .ready(b_ready));

    mips_regfile_gen #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_s (
        .clk(clk), .rst(rst), .read_reg_1(s_rr1), .read_reg_2(s_rr2),
        .read_data_1(s_rd1), .read_data_2(s_rd2), .write_reg(s_wr),
        .write_data(s_wd), .signal_reg_write(s_we), .ready(s_ready));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int a_first = -1, b_first = -1, s_first = -1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || s_ready !== 1'b0 || a_rd1 !== 32'h0 || a_rd2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b s_ready=%b rd1=%h rd2=%h, want 0 0 0 0",
                     a_ready, s_ready, a_rd1, a_rd2);
        end
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (a_ready === 1'b1 && a_first < 0) a_first = n;
            if (b_ready === 1'b1 && b_first < 0) b_first = n;
            if (s_ready === 1'b1 && s_first < 0) s_first = n;
            if (n == 5) begin
                checks++;
                if (a_rd1 !== 32'h0 || s_rd1 !== 16'h0) begin
                    errors++;
                    $display("FAIL clear_reads_zero: rd1=%h s_rd1=%h, want 0", a_rd1, s_rd1);
                end
            end
        end
        checks++;
        if (a_first != 32 || b_first != 32) begin
            errors++;
            $display("FAIL sweep_len_32: ready after %0d/%0d cycles, want 32", a_first, b_first);
        end
        checks++;
        if (s_first != 8) begin
            errors++;
            $display("FAIL sweep_len_8: ready after %0d cycles, want 8", s_first);
        end
    endtask

    task automatic test_cleared_contents();
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i);
            rr2 = 5'(31 - i);
            tick();
            if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0 || b_rd1 !== 32'h0 || b_rd2 !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cleared_contents: %0d nonzero reads, want 0", bad);
        end
    endtask

    task automatic test_write_read();
        rr1 = 5'd0; rr2 = 5'd0;
        wr = 5'd5; wd = 32'hDEADBEEF; we = 1'b1;
        tick();
        we = 1'b0;
        rr1 = 5'd5; rr2 = 5'd5;
        tick();
        checks++;
        if (a_rd1 !== 32'hDEADBEEF || b_rd1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read: a=%h b=%h, want deadbeef", a_rd1, b_rd1);
        end
        checks++;
        if (a_rd2 !== a_rd1 || a_rd2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL same_reg_both_ports: rd2=%h, want deadbeef", a_rd2);
        end
    endtask

    task automatic test_bypass();
        wr = 5'd7; wd = 32'h12345678; we = 1'b1;
        rr1 = 5'd7; rr2 = 5'd7;
        tick();
        we = 1'b0;
        checks++;
        if (a_rd1 !== 32'h12345678 || a_rd2 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_on: rd1=%h rd2=%h, want 12345678", a_rd1, a_rd2);
        end
        checks++;
        if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin
            errors++;
            $display("FAIL bypass_off: rd1=%h rd2=%h, want 00000000", b_rd1, b_rd2);
        end
        tick();
        checks++;
        if (b_rd1 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_off_stored: rd1=%h, want 12345678", b_rd1);
        end
    endtask

    task automatic test_zero_reg();
        wr = 5'd0; wd = 32'hFFFFFFFF; we = 1'b1;
        rr1 = 5'd0; rr2 = 5'd5;
        tick();
        we = 1'b0;
        checks++;
        if (a_rd1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_no_bypass: rd1=%h, want 0", a_rd1);
        end
        rr2 = 5'd0;
        tick();
        checks++;
        if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_on: rd1=%h rd2=%h, want 0", a_rd1, a_rd2);
        end
        checks++;
        if (b_rd1 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL zero_reg_off: rd1=%h, want ffffffff", b_rd1);
        end
    endtask

    task automatic test_mid_sweep_reset();
        int first = -1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr = 5'd3; wd = 32'h00000033; we = 1'b1;
        rr1 = 5'd5;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (a_ready === 1'b1 && first < 0) begin
                first = n;
                we = 1'b0;
            end
            if (n == 20) begin
                checks++;
                if (a_rd1 !== 32'h0) begin
                    errors++;
                    $display("FAIL mid_sweep_reads_zero: rd1=%h, want 0", a_rd1);
                end
            end
        end
        we = 1'b0;
        checks++;
        if (first != 32) begin
            errors++;
            $display("FAIL mid_sweep_len: ready after %0d cycles, want 32", first);
        end
        rr1 = 5'd3; rr2 = 5'd5;
        tick();
        checks++;
        if (a_rd1 !== 32'h0 || b_rd1 !== 32'h0) begin
            errors++;
            $display("FAIL clear_write_dropped: a=%h b=%h, want 0", a_rd1, b_rd1);
        end
        checks++;
        if (a_rd2 !== 32'h0) begin
            errors++;
            $display("FAIL reg5_recleared: rd2=%h, want 0", a_rd2);
        end
    endtask

    task automatic test_param_small();
        int bad = 0;
        s_wr = 3'd7; s_wd = 16'hA5A5; s_we = 1'b1;
        s_rr1 = 3'd1; s_rr2 = 3'd2;
        tick();
        s_we = 1'b0;
        s_rr1 = 3'd7; s_rr2 = 3'd7;
        tick();
        checks++;
        if (s_rd1 !== 16'hA5A5 || s_rd2 !== 16'hA5A5) begin
            errors++;
            $display("FAIL small_readback: rd1=%h rd2=%h, want a5a5", s_rd1, s_rd2);
        end
        for (int i = 1; i <= 6; i++) begin
            s_rr1 = 3'(i);
            s_rr2 = 3'(7 - i);
            tick();
            if (s_rd1 !== 16'h0 || (i > 1 && s_rd2 !== 16'h0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL small_others_zero: %0d nonzero reads, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        wr = 5'd10; wd = 32'hAAAA0001; we = 1'b1;
        rr1 = 5'd0; rr2 = 5'd0;
        tick();
        wr = 5'd11; wd = 32'hBBBB0002;
        rr1 = 5'd10;
        tick();
        we = 1'b0;
        rr1 = 5'd10; rr2 = 5'd11;
        checks++;
        if (a_rd1 !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL b2b_first: rd1=%h, want aaaa0001", a_rd1);
        end
        tick();
        checks++;
        if (a_rd1 !== 32'hAAAA0001 || a_rd2 !== 32'hBBBB0002 || b_rd2 !== 32'hBBBB0002) begin
            errors++;
            $display("FAIL b2b_both: rd1=%h rd2=%h b_rd2=%h, want aaaa0001 bbbb0002 bbbb0002",
                     a_rd1, a_rd2, b_rd2);
        end
    endtask

    initial begin
        test_reset();
        test_cleared_contents();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_back_to_back();
        test_mid_sweep_reset();
        test_param_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
